// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
// Holds the FSM state encoding, parity mode values and the requester arbiter.
package uart_pkg;

  localparam int NUM_REQ = 4;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Returns {found, index}. The search begins one past the last winner, so the
  // lowest offset k with a valid request wins; iterating k downward lets the
  // final overwrite be the closest requester.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                         input logic [1:0]         last);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (valid[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake bundle: four valid/data lanes and a one-hot ready.
// Requesters use the master view, the scheduler the slave view.
interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clocks within one serial bit and flags the last one.
// Held at zero while clr is high so every bit starts from a clean count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign bit_done = !clr && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Wrapping on bit_done doubles as the clear for the next state's entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || bit_done) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Four-requester UART transmitter: round-robin picks one pending byte per
// frame and serialises it as start, data (LSB first), optional parity, stop.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_BITS  = 1,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_scheduler_if.slave  req,
  output logic                TX,
  output logic                busy,
  output logic [1:0]          grant_id
);

  localparam int  BIT_W    = $clog2(DATA_BITS + 1);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);

  uart_state_e          state_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_reg;
  logic [1:0]           last_reg;
  logic                 tx_reg;
  logic                 busy_reg;
  logic [1:0]           grant_reg;

  logic [2:0]           pick;
  logic                 pick_valid;
  logic [1:0]           pick_idx;
  logic                 accept;
  logic                 baud_clr;
  logic                 bit_done;
  logic [DATA_BITS-1:0] win_data;

  assign pick                  = rr_pick(req.req_valid, last_reg);
  assign {pick_valid, pick_idx} = pick;
  // Ready must follow the live valid so a requester that drops out before its
  // turn simply forfeits; rst_n gating keeps ready low throughout reset.
  assign accept   = (state_reg == ST_IDLE) && rst_n && pick_valid;
  assign win_data = req.req_data[pick_idx];
  assign baud_clr = (state_reg == ST_IDLE);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req.req_ready[gi] = accept && (pick_idx == 2'(gi));
  end

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  // TX is loaded alongside each state change so the line switches in the same
  // cycle the new state becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      last_reg    <= 2'd3;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      grant_reg   <= 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg   <= ST_START;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            grant_reg   <= pick_idx;
            last_reg    <= pick_idx;
            shift_reg   <= win_data;
            parity_reg  <= (^win_data) ^ PAR_ODD;
            bit_cnt_reg <= '0;
          end
        end

        ST_START: begin
          if (bit_done) begin
            state_reg <= ST_DATA;
            tx_reg    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt_reg <= '0;
              if (PARITY_BITS != 0) begin
                state_reg <= ST_PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= ST_STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            state_reg   <= ST_STOP;
            tx_reg      <= 1'b1;
            bit_cnt_reg <= '0;
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            if (bit_cnt_reg == BIT_W'(STOP_BITS - 1)) begin
              state_reg   <= ST_IDLE;
              busy_reg    <= 1'b0;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            tx_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign TX       = tx_reg;
  assign busy     = busy_reg;
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler at 4 clocks per bit: a scoreboard of
// expected (requester, byte) pairs is checked against decoded TX frames.
module tb_uart_tx_scheduler;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]      req_valid;
  logic [3:0][7:0] req_data;
  int              sel;

  uart_tx_scheduler_if #(.DATA_BITS(8)) if0 ();
  uart_tx_scheduler_if #(.DATA_BITS(8)) if1 ();
  uart_tx_scheduler_if #(.DATA_BITS(8)) if2 ();

  assign if0.req_valid = (sel == 0) ? req_valid : 4'b0000;
  assign if1.req_valid = (sel == 1) ? req_valid : 4'b0000;
  assign if2.req_valid = (sel == 2) ? req_valid : 4'b0000;
  assign if0.req_data  = req_data;
  assign if1.req_data  = req_data;
  assign if2.req_data  = req_data;

  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic [1:0] gid0, gid1, gid2;

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .req(if0), .TX(tx0), .busy(busy0), .grant_id(gid0));

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .req(if1), .TX(tx1), .busy(busy1), .grant_id(gid1));

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB), .PARITY_BITS(0)) dut_nopar (
    .clk(clk), .rst_n(rst_n), .req(if2), .TX(tx2), .busy(busy2), .grant_id(gid2));

  logic       o_tx, o_busy;
  logic [1:0] o_gid;
  logic [3:0] o_ready;
  assign o_tx    = (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
  assign o_busy  = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign o_gid   = (sel == 0) ? gid0 : (sel == 1) ? gid1 : gid2;
  assign o_ready = (sel == 0) ? if0.req_ready : (sel == 1) ? if1.req_ready : if2.req_ready;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } sb_t;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    sb.push_back('{id: id, data: data});
  endtask

  function automatic int nbits(input int s);
    return (s == 2) ? 10 : 11;
  endfunction

  // Frame bits in transmission order, bit 0 first; unused high bits idle at 1.
  function automatic logic [15:0] exp_frame(input logic [7:0] d, input int s);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (s == 0) f[9] = ~(^d);
    if (s == 1) f[9] = ^d;
    return f;
  endfunction

  // mode 0: drop the winner's valid and scramble its data after acceptance
  // mode 1: keep every valid as is; mode 2: drop all valids and scramble
  task automatic run_frame(input int mode, input bit b2b);
    int          nb;
    bit          seen;
    sb_t         e;
    logic [1:0]  idx;
    logic [15:0] got;
    nb   = nbits(sel);
    seen = 1'b0;
    for (int w = 0; w < 300 && !seen; w++) begin
      @(negedge clk);
      if (o_ready != 4'b0000) seen = 1'b1;
    end
    chk("accept_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("ready_onehot", 32'(o_ready), 32'(4'b0001 << e.id));
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_tx", 32'(o_tx), 32'd1);
    if (b2b) chk("b2b_gap", 32'(cyc - last_acc), 32'(1 + nb * CPB));
    last_acc = cyc;
    idx = e.id;
    @(posedge clk);
    #1;
    if (mode == 0) begin
      req_valid[idx] = 1'b0;
      req_data[idx]  = ~req_data[idx];
    end else if (mode == 2) begin
      req_valid     = 4'b0000;
      req_data[idx] = ~req_data[idx];
    end
    @(negedge clk);
    chk("busy_after_accept", 32'(o_busy), 32'd1);
    chk("grant_id", 32'(o_gid), 32'(e.id));
    got = '1;
    @(negedge clk);
    got[0] = o_tx;
    for (int j = 1; j < nb; j++) begin
      repeat (CPB) @(negedge clk);
      got[j] = o_tx;
    end
    repeat (2) @(negedge clk);
    chk("busy_last_stop", 32'(o_busy), 32'd1);
    $display("frame sel=%0d id=%0d data=%02h bits=%04h exp=%04h", sel, e.id, e.data, got,
             exp_frame(e.data, sel));
    chk("frame_bits", 32'(got), 32'(exp_frame(e.data, sel)));
  endtask

  initial begin
    sel       = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_gid", 32'(o_gid), 32'd0);
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four pending: served in index order with one idle clock between.
    req_data[0] = 8'hA0;
    req_data[1] = 8'hA1;
    req_data[2] = 8'hA2;
    req_data[3] = 8'hA3;
    for (int i = 0; i < 4; i++) push(2'(i), 8'hA0 + 8'(i));
    req_valid = 4'b1111;
    run_frame(0, 1'b0);
    for (int i = 1; i < 4; i++) run_frame(0, 1'b1);

    // Requesters 0 and 2 held: grants must alternate.
    req_data[0] = 8'hC0;
    req_data[2] = 8'hC2;
    push(2'd0, 8'hC0);
    push(2'd2, 8'hC2);
    push(2'd0, 8'hC0);
    push(2'd2, 8'hC2);
    req_valid = 4'b0101;
    run_frame(1, 1'b0);
    run_frame(1, 1'b1);
    run_frame(1, 1'b1);
    run_frame(2, 1'b1);

    // Single request 0x55.
    req_data[0] = 8'h55;
    push(2'd0, 8'h55);
    req_valid = 4'b0001;
    run_frame(0, 1'b0);

    // Zero payload against odd, even and no parity.
    for (int s = 0; s < 3; s++) begin
      sel         = s;
      req_data[0] = 8'h00;
      push(2'd0, 8'h00);
      req_valid = 4'b0001;
      run_frame(0, 1'b0);
    end

    // Reset during data bit 3 aborts the frame and restores the pointer.
    sel         = 0;
    req_data[0] = 8'h30;
    req_valid   = 4'b0001;
    begin
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 300 && !seen; w++) begin
        @(negedge clk);
        if (o_ready[0]) seen = 1'b1;
      end
      chk("abort_accept_seen", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (17) @(posedge clk);
    #1;
    chk("pre_rst_tx_bit3", 32'(o_tx), 32'd0);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(o_tx), 32'd1);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    req_valid = 4'b0011;
    run_frame(0, 1'b0);
    run_frame(0, 1'b1);

    repeat (4) @(negedge clk);
    chk("final_idle_busy", 32'(o_busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
